// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//   Bundles the decode-side issue bus, the variable-latency writeback bus, the
//   flush strobe and the scoreboard status outputs into one interface.
//
//   Parameters
//     REG_ID_WIDTH  register index width (2**REG_ID_WIDTH architectural regs)
//     NUM_SRC       source operands checked per decoded instruction
//     LAT_WIDTH     latency field width; all-ones encodes "variable latency"
//
//   Signals (direction seen from the scoreboard, i.e. the slave modport)
//     id_valid      in   instruction present in decode
//     id_src        in   NUM_SRC packed source ids, src k at [k*RW +: RW]
//     id_src_used   in   per-source valid mask
//     id_dest_we    in   instruction writes id_dest
//     id_dest       in   destination register id
//     id_lat        in   0 untracked, 1..max-1 fixed cycles, max variable
//     wb_valid      in   variable-latency result written back this cycle
//     wb_dest       in   writeback register id
//     flush         in   pipeline flush (mispredict / trap)
//     stall         out  hold PC, IF/ID and ID this cycle
//     busy          out  at least one register has a pending producer
//
//   Optional build macro HAZARD_SCOREBOARD_PERF_EN adds:
//     stall_cycles      out [31:0] saturating count of stalled cycles
//     raw_stall_cycles  out [31:0] saturating count of source-caused stalls
//
//   modport master : pipeline / decode side
//   modport slave  : the scoreboard
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int REG_ID_WIDTH = 5,
  parameter int NUM_SRC      = 2,
  parameter int LAT_WIDTH    = 3
);

  logic                            id_valid;
  logic [NUM_SRC*REG_ID_WIDTH-1:0] id_src;
  logic [NUM_SRC-1:0]              id_src_used;
  logic                            id_dest_we;
  logic [REG_ID_WIDTH-1:0]         id_dest;
  logic [LAT_WIDTH-1:0]            id_lat;
  logic                            wb_valid;
  logic [REG_ID_WIDTH-1:0]         wb_dest;
  logic                            flush;
  logic                            stall;
  logic                            busy;
`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0]                     stall_cycles;
  logic [31:0]                     raw_stall_cycles;
`endif

  modport master (
    output id_valid,
    output id_src,
    output id_src_used,
    output id_dest_we,
    output id_dest,
    output id_lat,
    output wb_valid,
    output wb_dest,
    output flush,
    input  stall,
    input  busy
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    input  stall_cycles,
    input  raw_stall_cycles
`endif
  );

  modport slave (
    input  id_valid,
    input  id_src,
    input  id_src_used,
    input  id_dest_we,
    input  id_dest,
    input  id_lat,
    input  wb_valid,
    input  wb_dest,
    input  flush,
    output stall,
    output busy
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output stall_cycles,
    output raw_stall_cycles
`endif
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Per-register scoreboard that stalls decode on RAW or WAW hazards against
//   any in-flight multi-cycle producer. Fixed-latency producers (MUL/DIV)
//   retire themselves by a countdown; variable-latency producers (loads) are
//   retired by the writeback bus.
//
//   Ports
//     clk    in  rising-edge clock
//     reset  in  synchronous, active-high; clears every entry
//     sb     hazard_scoreboard_if.slave (issue, writeback, flush, stall, busy)
//
//   Optional feature macro: HAZARD_SCOREBOARD_PERF_EN
//     When defined, sb.stall_cycles / sb.raw_stall_cycles are driven by
//     saturating 32-bit performance counters. When undefined they do not exist.
//
//   Timing
//     stall is purely combinational from registered entry state plus the
//     current decode inputs, so a hazard is flagged in the same cycle the
//     dependent instruction sits in decode. Issue/clear take effect at the
//     next rising edge.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_ID_WIDTH = 5,
  parameter int NUM_SRC      = 2,
  parameter int LAT_WIDTH    = 3
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
);

  localparam int                   NUM_REGS = 2 ** REG_ID_WIDTH;
  localparam logic [LAT_WIDTH-1:0] LAT_VAR  = {LAT_WIDTH{1'b1}};
  localparam logic [LAT_WIDTH-1:0] LAT_ONE  = LAT_WIDTH'(1);

  genvar gi;

  // One bit per architectural register: a producer is still in flight.
  logic [NUM_REGS-1:0] pend_vec;

  logic [NUM_SRC-1:0]  src_hit;
  logic                dest_hit;
  logic                stall_comb;
  logic                issue_fire;
  logic                issue_is_var;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // Register 0 is hard-wired and its entry never becomes pending, but the id
  // is masked explicitly too so a stray index can never raise a hazard.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ID_WIDTH-1:0] src_id;
      assign src_id      = sb.id_src[gi*REG_ID_WIDTH +: REG_ID_WIDTH];
      assign src_hit[gi] = sb.id_src_used[gi] && (src_id != '0) && pend_vec[src_id];
    end
  endgenerate

  // WAW: a new writer must not overtake an older in-flight writer.
  assign dest_hit = sb.id_dest_we && (sb.id_dest != '0) && pend_vec[sb.id_dest];

  // A flushed instruction is being squashed, so it never needs to wait.
  assign stall_comb = sb.id_valid && !sb.flush && ((|src_hit) || dest_hit);

  // Latency 0 means the result is forwarded in time and needs no tracking.
  assign issue_fire   = sb.id_valid && !stall_comb && !sb.flush && sb.id_dest_we &&
                        (sb.id_dest != '0) && (sb.id_lat != '0);
  assign issue_is_var = (sb.id_lat == LAT_VAR);

  // ---------------------------------------------------------------------------
  // Scoreboard entries
  // ---------------------------------------------------------------------------
  // Each entry owns its own state so the per-register update rules stay local.
  // Priority inside an entry: reset, then a new issue, then retirement. An
  // issue can never collide with retirement of the same register because a
  // pending destination forces a WAW stall, which blocks the issue.
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        assign pend_vec[gi] = 1'b0;
      end else begin : g_live
        logic                 pend_reg;
        logic                 var_reg;
        logic [LAT_WIDTH-1:0] cnt_reg;
        logic                 issue_here;
        logic                 wb_here;

        assign issue_here = issue_fire && (sb.id_dest == REG_ID_WIDTH'(gi));
        assign wb_here    = sb.wb_valid && (sb.wb_dest == REG_ID_WIDTH'(gi));

        always_ff @(posedge clk) begin
          if (reset) begin
            pend_reg <= 1'b0;
            var_reg  <= 1'b0;
            cnt_reg  <= '0;
          end else if (issue_here) begin
            pend_reg <= 1'b1;
            var_reg  <= issue_is_var;
            cnt_reg  <= issue_is_var ? '0 : sb.id_lat;
          end else if (pend_reg && var_reg) begin
            // Loads already committed to return data, so a flush leaves them
            // alone; only their own writeback retires them.
            if (wb_here) begin
              pend_reg <= 1'b0;
              var_reg  <= 1'b0;
            end
          end else if (pend_reg) begin
            // Fixed-latency producer: the edge that takes cnt from 1 to 0 also
            // drops pend, giving exactly id_lat stalled cycles for a dependent.
            // A flush kills the producer outright.
            if (sb.flush || (cnt_reg == LAT_ONE)) begin
              pend_reg <= 1'b0;
              cnt_reg  <= '0;
            end else begin
              cnt_reg  <= cnt_reg - LAT_ONE;
            end
          end
        end

        assign pend_vec[gi] = pend_reg;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sb.stall = stall_comb;
  assign sb.busy  = |pend_vec;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  // A cycle where both a source and the destination hit is attributed to the
  // source, since the RAW dependency is the one that must be honoured.
  logic [31:0] stall_cycles_reg;
  logic [31:0] raw_stall_cycles_reg;
  logic        raw_stall;

  assign raw_stall = stall_comb && (|src_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg     <= '0;
      raw_stall_cycles_reg <= '0;
    end else begin
      if (stall_comb && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      if (raw_stall && (raw_stall_cycles_reg != 32'hFFFF_FFFF)) begin
        raw_stall_cycles_reg <= raw_stall_cycles_reg + 32'd1;
      end
    end
  end

  assign sb.stall_cycles     = stall_cycles_reg;
  assign sb.raw_stall_cycles = raw_stall_cycles_reg;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed scenarios with hand-derived expectations plus a randomized run
//   checked against a behavioural model. The model keeps, per register, the
//   number of cycles until a fixed producer is done and a flag for an
//   outstanding load.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int             RW = 5;
  localparam int             NS = 2;
  localparam int             LW = 3;
  localparam int             NR = 32;
  localparam logic [LW-1:0]  LAT_VAR = 3'b111;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_ID_WIDTH(RW), .NUM_SRC(NS), .LAT_WIDTH(LW)) sb_if ();

  hazard_scoreboard #(.REG_ID_WIDTH(RW), .NUM_SRC(NS), .LAT_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  int pass_count  = 0;
  int check_count = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int rem  [NR];   // cycles left before a fixed-latency result is ready
  bit mvar [NR];   // an outstanding load targets this register
`ifdef HAZARD_SCOREBOARD_PERF_EN
  longint m_stall_cycles;
  longint m_raw_cycles;
`endif

  function automatic bit m_pend(int r);
    return (r != 0) && ((rem[r] > 0) || mvar[r]);
  endfunction

  function automatic bit m_src_hit();
    bit h;
    h = 1'b0;
    for (int k = 0; k < NS; k++) begin
      int r;
      r = int'(sb_if.id_src[k*RW +: RW]);
      if (sb_if.id_src_used[k] && m_pend(r)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic bit m_stall();
    return sb_if.id_valid && !sb_if.flush &&
           (m_src_hit() || (sb_if.id_dest_we && m_pend(int'(sb_if.id_dest))));
  endfunction

  function automatic bit m_busy();
    bit b;
    b = 1'b0;
    for (int r = 0; r < NR; r++) if (m_pend(r)) b = 1'b1;
    return b;
  endfunction

  task automatic model_tick();
    bit st;
    bit sh;
    st = m_stall();
    sh = m_src_hit();
    if (reset) begin
      for (int r = 0; r < NR; r++) begin
        rem[r]  = 0;
        mvar[r] = 1'b0;
      end
`ifdef HAZARD_SCOREBOARD_PERF_EN
      m_stall_cycles = 0;
      m_raw_cycles   = 0;
`endif
    end else begin
`ifdef HAZARD_SCOREBOARD_PERF_EN
      if (st) m_stall_cycles++;
      if (st && sh) m_raw_cycles++;
`endif
      for (int r = 0; r < NR; r++) begin
        if (sb_if.flush) rem[r] = 0;
        else if (rem[r] > 0) rem[r]--;
      end
      if (sb_if.wb_valid && mvar[int'(sb_if.wb_dest)]) mvar[int'(sb_if.wb_dest)] = 1'b0;
      if (sb_if.id_valid && !st && !sb_if.flush && sb_if.id_dest_we &&
          sb_if.id_dest != 0 && sb_if.id_lat != 0) begin
        if (sb_if.id_lat == LAT_VAR) mvar[int'(sb_if.id_dest)] = 1'b1;
        else rem[int'(sb_if.id_dest)] = int'(sb_if.id_lat);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_tick();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus driver
  // ---------------------------------------------------------------------------
  task automatic drive(input bit v, input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                       input logic [1:0] used, input bit we, input logic [RW-1:0] d,
                       input logic [LW-1:0] lat, input bit wbv, input logic [RW-1:0] wbd,
                       input bit fl);
    sb_if.id_valid    = v;
    sb_if.id_src      = {s1, s0};
    sb_if.id_src_used = used;
    sb_if.id_dest_we  = we;
    sb_if.id_dest     = d;
    sb_if.id_lat      = lat;
    sb_if.wb_valid    = wbv;
    sb_if.wb_dest     = wbd;
    sb_if.flush       = fl;
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    #1;
    check_count++;
    if (sb_if.stall !== 1'b0) $display("FAIL reset_stall: stall=%b expected 0", sb_if.stall);
    else pass_count++;
    check_count++;
    if (sb_if.busy !== 1'b0) $display("FAIL reset_busy: busy=%b expected 0", sb_if.busy);
    else pass_count++;
    $display("reset: stall=%b busy=%b", sb_if.stall, sb_if.busy);
    reset = 1'b0;
    // Load x3 in flight, then reset with a dependent waiting in decode.
    @(negedge clk);
    drive(1'b1, '0, '0, 2'b00, 1'b1, 5'd3, LAT_VAR, 1'b0, '0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd3, '0, 2'b01, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    check_count++;
    if (sb_if.stall !== 1'b1) $display("FAIL reset_pre_stall: stall=%b expected 1", sb_if.stall);
    else pass_count++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_count++;
    if (sb_if.stall !== 1'b0 || sb_if.busy !== 1'b0)
      $display("FAIL reset_mid_op: stall=%b busy=%b expected 0 0", sb_if.stall, sb_if.busy);
    else pass_count++;
    $display("reset mid-op: stall=%b busy=%b", sb_if.stall, sb_if.busy);
    drive_idle();
  endtask

  task automatic test_fixed_latency();
    do_reset();
    @(negedge clk);
    drive(1'b1, '0, '0, 2'b00, 1'b1, 5'd5, 3'd3, 1'b0, '0, 1'b0);
    #1;
    check_count++;
    if (sb_if.stall !== 1'b0) $display("FAIL fixed_issue: stall=%b expected 0", sb_if.stall);
    else pass_count++;
    for (int c = 0; c < 4; c++) begin
      bit exp_st;
      exp_st = (c < 3);
      @(negedge clk);
      drive(1'b1, 5'd5, '0, 2'b01, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      #1;
      $display("fixed x5 c%0d: stall=%b busy=%b", c, sb_if.stall, sb_if.busy);
      check_count++;
      if (sb_if.stall !== exp_st)
        $display("FAIL fixed_stall c%0d: stall=%b expected %b", c, sb_if.stall, exp_st);
      else pass_count++;
      check_count++;
      if (sb_if.busy !== exp_st)
        $display("FAIL fixed_busy c%0d: busy=%b expected %b", c, sb_if.busy, exp_st);
      else pass_count++;
    end
    drive_idle();
  endtask

  task automatic test_variable_latency();
    do_reset();
    @(negedge clk);
    drive(1'b1, '0, '0, 2'b00, 1'b1, 5'd7, LAT_VAR, 1'b0, '0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bit exp_st;
      exp_st = (c < 4);
      @(negedge clk);
      drive(1'b1, '0, 5'd7, 2'b10, 1'b0, '0, '0, (c == 3), 5'd7, 1'b0);
      #1;
      $display("load x7 c%0d: wb=%b stall=%b busy=%b", c, sb_if.wb_valid, sb_if.stall, sb_if.busy);
      check_count++;
      if (sb_if.stall !== exp_st || sb_if.busy !== exp_st)
        $display("FAIL var_stall c%0d: stall=%b busy=%b expected %b", c, sb_if.stall, sb_if.busy, exp_st);
      else pass_count++;
    end
    drive_idle();
  endtask

  task automatic test_reg_zero();
    do_reset();
    @(negedge clk);
    drive(1'b1, '0, '0, 2'b00, 1'b1, 5'd0, 3'd3, 1'b0, '0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, LAT_VAR, (c == 1), 5'd0, 1'b0);
      #1;
      $display("x0 c%0d: stall=%b busy=%b", c, sb_if.stall, sb_if.busy);
      check_count++;
      if (sb_if.stall !== 1'b0 || sb_if.busy !== 1'b0)
        $display("FAIL reg_zero c%0d: stall=%b busy=%b expected 0 0", c, sb_if.stall, sb_if.busy);
      else pass_count++;
    end
    drive_idle();
  endtask

  task automatic test_waw();
    do_reset();
    @(negedge clk);
    drive(1'b1, '0, '0, 2'b00, 1'b1, 5'd9, LAT_VAR, 1'b0, '0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bit exp_st;
      exp_st = (c < 3);
      @(negedge clk);
      drive(1'b1, '0, '0, 2'b00, 1'b1, 5'd9, 3'd0, (c == 2), 5'd9, 1'b0);
      #1;
      $display("waw x9 c%0d: stall=%b busy=%b", c, sb_if.stall, sb_if.busy);
      check_count++;
      if (sb_if.stall !== exp_st || sb_if.busy !== exp_st)
        $display("FAIL waw c%0d: stall=%b busy=%b expected %b", c, sb_if.stall, sb_if.busy, exp_st);
      else pass_count++;
    end
    drive_idle();
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    drive(1'b1, '0, '0, 2'b00, 1'b1, 5'd4, 3'd5, 1'b0, '0, 1'b0);
    @(negedge clk);
    drive(1'b1, '0, '0, 2'b00, 1'b1, 5'd6, LAT_VAR, 1'b0, '0, 1'b0);
    #1;
    check_count++;
    if (sb_if.stall !== 1'b0 || sb_if.busy !== 1'b1)
      $display("FAIL flush_setup: stall=%b busy=%b expected 0 1", sb_if.stall, sb_if.busy);
    else pass_count++;
    @(negedge clk);
    drive(1'b1, 5'd4, '0, 2'b01, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    #1;
    $display("flush cycle: stall=%b busy=%b", sb_if.stall, sb_if.busy);
    check_count++;
    if (sb_if.stall !== 1'b0)
      $display("FAIL flush_masks_stall: stall=%b expected 0", sb_if.stall);
    else pass_count++;
    @(negedge clk);
    drive(1'b1, 5'd4, '0, 2'b01, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    $display("after flush src x4: stall=%b busy=%b", sb_if.stall, sb_if.busy);
    check_count++;
    if (sb_if.stall !== 1'b0 || sb_if.busy !== 1'b1)
      $display("FAIL flush_x4_freed: stall=%b busy=%b expected 0 1", sb_if.stall, sb_if.busy);
    else pass_count++;
    for (int c = 0; c < 3; c++) begin
      bit exp_st;
      exp_st = (c < 2);
      @(negedge clk);
      drive(1'b1, 5'd6, '0, 2'b01, 1'b0, '0, '0, (c == 1), 5'd6, 1'b0);
      #1;
      $display("after flush src x6 c%0d: stall=%b busy=%b", c, sb_if.stall, sb_if.busy);
      check_count++;
      if (sb_if.stall !== exp_st || sb_if.busy !== exp_st)
        $display("FAIL flush_x6_kept c%0d: stall=%b busy=%b expected %b", c, sb_if.stall, sb_if.busy, exp_st);
      else pass_count++;
    end
    drive_idle();
  endtask

`ifdef HAZARD_SCOREBOARD_PERF_EN
  task automatic test_perf();
    do_reset();
    @(negedge clk);
    check_count++;
    if (sb_if.stall_cycles !== 32'd0 || sb_if.raw_stall_cycles !== 32'd0)
      $display("FAIL perf_reset: stall_cycles=%0d raw=%0d expected 0 0",
               sb_if.stall_cycles, sb_if.raw_stall_cycles);
    else pass_count++;
    drive(1'b1, '0, '0, 2'b00, 1'b1, 5'd9, LAT_VAR, 1'b0, '0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 6) drive(1'b1, 5'd9, '0, 2'b01, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      else drive(1'b1, '0, '0, 2'b00, 1'b1, 5'd9, 3'd0, (c == 9), 5'd9, 1'b0);
    end
    @(negedge clk);
    drive_idle();
    #1;
    $display("perf: stall_cycles=%0d raw_stall_cycles=%0d", sb_if.stall_cycles, sb_if.raw_stall_cycles);
    check_count++;
    if (sb_if.stall_cycles !== 32'd10)
      $display("FAIL perf_stall_cycles: got %0d expected 10", sb_if.stall_cycles);
    else pass_count++;
    check_count++;
    if (sb_if.raw_stall_cycles !== 32'd6)
      $display("FAIL perf_raw_cycles: got %0d expected 6", sb_if.raw_stall_cycles);
    else pass_count++;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bit exp_st;
      bit exp_busy;
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 9) < 7),
            RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 6),
            RW'($urandom_range(0, 7)), LW'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 3), RW'($urandom_range(0, 7)),
            ($urandom_range(0, 29) == 0));
      #1;
      exp_st   = m_stall();
      exp_busy = m_busy();
      check_count++;
      if (sb_if.stall !== exp_st)
        $display("FAIL rand_stall c%0d: stall=%b expected %b", c, sb_if.stall, exp_st);
      else pass_count++;
      check_count++;
      if (sb_if.busy !== exp_busy)
        $display("FAIL rand_busy c%0d: busy=%b expected %b", c, sb_if.busy, exp_busy);
      else pass_count++;
      if (!reset && sb_if.id_valid && !exp_st && !sb_if.flush && sb_if.id_dest_we &&
          sb_if.id_dest != 0 && sb_if.id_lat != 0)
        $display("rand c%0d: issue x%0d lat=%0d", c, sb_if.id_dest, sb_if.id_lat);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
`ifdef HAZARD_SCOREBOARD_PERF_EN
    #1;
    check_count++;
    if (longint'(sb_if.stall_cycles) != m_stall_cycles || longint'(sb_if.raw_stall_cycles) != m_raw_cycles)
      $display("FAIL rand_perf: stall_cycles=%0d raw=%0d expected %0d %0d",
               sb_if.stall_cycles, sb_if.raw_stall_cycles, m_stall_cycles, m_raw_cycles);
    else pass_count++;
`endif
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_fixed_latency();
    test_variable_latency();
    test_reg_zero();
    test_waw();
    test_flush();
`ifdef HAZARD_SCOREBOARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
